// File: rtl/wb_shared_bus_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : wb_shared_bus_arb_if
// Purpose  : Signal bundle between NM Wishbone masters, the shared-bus
//            interconnect and NS slaves.
// Revision : 1.0 - initial release
// ============================================================================
interface wb_shared_bus_arb_if #(
    parameter int WB_DATA_WIDTH = 32,
    parameter int WB_ADDR_WIDTH = 32,
    parameter int WB_SEL_WIDTH  = WB_DATA_WIDTH / 8,
    parameter int NM            = 2,
    parameter int NS            = 3
);
    logic [NM*WB_ADDR_WIDTH-1:0] m_adr_i;
    logic [NM*WB_DATA_WIDTH-1:0] m_dat_i;
    logic [NM-1:0]               m_we_i;
    logic [NM*WB_SEL_WIDTH-1:0]  m_sel_i;
    logic [NM-1:0]               m_stb_i;
    logic [NM-1:0]               m_cyc_i;
    logic [NM-1:0]               m_ack_o;
    logic [NM-1:0]               m_err_o;
    logic [WB_DATA_WIDTH-1:0]    m_dat_o;
    logic [WB_ADDR_WIDTH-1:0]    s_adr_o;
    logic [WB_DATA_WIDTH-1:0]    s_dat_o;
    logic                        s_we_o;
    logic [WB_SEL_WIDTH-1:0]     s_sel_o;
    logic [NS-1:0]               s_stb_o;
    logic [NS-1:0]               s_cyc_o;
    logic [NS-1:0]               s_ack_i;
    logic [NS*WB_DATA_WIDTH-1:0] s_dat_i;
    logic [NM-1:0]               grant_o;

    // Interconnect view: it masters the slave side of the bus.
    modport master (
        input  m_adr_i, m_dat_i, m_we_i, m_sel_i, m_stb_i, m_cyc_i,
        input  s_ack_i, s_dat_i,
        output m_ack_o, m_err_o, m_dat_o,
        output s_adr_o, s_dat_o, s_we_o, s_sel_o, s_stb_o, s_cyc_o,
        output grant_o
    );

    // Attached-agent view (masters and slaves around the interconnect).
    modport slave (
        output m_adr_i, m_dat_i, m_we_i, m_sel_i, m_stb_i, m_cyc_i,
        output s_ack_i, s_dat_i,
        input  m_ack_o, m_err_o, m_dat_o,
        input  s_adr_o, s_dat_o, s_we_o, s_sel_o, s_stb_o, s_cyc_o,
        input  grant_o
    );
endinterface
`default_nettype wire

// File: rtl/wb_shared_bus_arb.sv
`default_nettype none
// ============================================================================
// Module   : wb_shared_bus_arb
// Purpose  : Wishbone B4 classic shared bus, NM masters / NS slaves, round-
//            robin grant held for a whole CYC, mask/base decode, ERR on miss.
//            Optional watchdog enabled by defining WB_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module wb_shared_bus_arb #(
    parameter int WB_DATA_WIDTH = 32,
    parameter int WB_ADDR_WIDTH = 32,
    parameter int WB_SEL_WIDTH  = WB_DATA_WIDTH / 8,
    parameter int NM            = 2,
    parameter int NS            = 3,
    parameter logic [NS*WB_ADDR_WIDTH-1:0] SLAVE_BASE =
        {32'h0002_0000, 32'h0001_0000, 32'h0000_0000},
    parameter logic [NS*WB_ADDR_WIDTH-1:0] SLAVE_MASK =
        {32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_0000},
    parameter int TIMEOUT_CYCLES = 16
) (
    input  wire logic           clk_i,
    input  wire logic           rst_i,
    wb_shared_bus_arb_if.master bus
);

    localparam int c_AW     = WB_ADDR_WIDTH;
    localparam int c_DW     = WB_DATA_WIDTH;
    localparam int c_SW     = WB_SEL_WIDTH;
    localparam int c_IDX_W  = (NM > 1) ? $clog2(NM) : 1;
    localparam int c_SIDX_W = (NS > 1) ? $clog2(NS) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_ERR   = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_IDX_W-1:0]  r_gidx;
    logic [c_IDX_W-1:0]  w_gidx_nxt;
    logic [c_IDX_W-1:0]  r_ptr;
    logic [c_IDX_W-1:0]  w_ptr_nxt;
    logic [c_IDX_W-1:0]  w_rr_idx;
    logic                w_rr_found;

    logic                w_granted;
    logic                w_g_cyc;
    logic                w_g_stb;
    logic                w_g_we;
    logic [c_AW-1:0]     w_g_adr;
    logic [c_DW-1:0]     w_g_dat;
    logic [c_SW-1:0]     w_g_sel;
    logic [NM-1:0]       w_grant_oh;

    logic                w_any_hit;
    logic [c_SIDX_W-1:0] w_sel_idx;
    logic [NS-1:0]       w_sel_oh;
    logic                w_s_ack;
    logic                w_active;
    logic                w_timeout;

    // Round-robin search starting just after the last owner.
    always_comb begin
        w_rr_idx   = r_ptr;
        w_rr_found = 1'b0;
        for (int i = 1; i <= NM; i++) begin
            if (!w_rr_found && bus.m_cyc_i[(int'(r_ptr) + i) % NM]) begin
                w_rr_found = 1'b1;
                w_rr_idx   = c_IDX_W'((int'(r_ptr) + i) % NM);
            end
        end
    end

    always_comb begin
        w_granted  = (r_state != S_IDLE);
        w_g_cyc    = w_granted & bus.m_cyc_i[r_gidx];
        w_g_stb    = w_granted & bus.m_stb_i[r_gidx];
        w_g_we     = bus.m_we_i[r_gidx];
        w_g_adr    = bus.m_adr_i[int'(r_gidx)*c_AW +: c_AW];
        w_g_dat    = bus.m_dat_i[int'(r_gidx)*c_DW +: c_DW];
        w_g_sel    = bus.m_sel_i[int'(r_gidx)*c_SW +: c_SW];
        w_grant_oh = w_granted ? (NM'(1) << r_gidx) : '0;
    end

    // Scan downwards so the lowest-numbered matching slave wins on overlap.
    always_comb begin
        w_any_hit = 1'b0;
        w_sel_idx = '0;
        for (int s = NS - 1; s >= 0; s--) begin
            if ((w_g_adr & SLAVE_MASK[s*c_AW +: c_AW]) == SLAVE_BASE[s*c_AW +: c_AW]) begin
                w_any_hit = 1'b1;
                w_sel_idx = c_SIDX_W'(s);
            end
        end
    end

    assign w_sel_oh = NS'(1) << w_sel_idx;
    assign w_s_ack  = bus.s_ack_i[w_sel_idx];
    assign w_active = (r_state == S_GRANT) && w_g_cyc && w_any_hit && !w_timeout;

`ifdef WB_ARB_TIMEOUT_EN
    localparam int c_TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_TO_W-1:0] r_to_cnt;
    logic              w_waiting;

    assign w_waiting = (r_state == S_GRANT) && w_g_cyc && w_g_stb && w_any_hit && !w_s_ack;
    assign w_timeout = w_waiting && (r_to_cnt == c_TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_to_cnt <= '0;
        end else if (w_waiting && !w_timeout) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end else begin
            r_to_cnt <= '0;
        end
    end
`else
    // No watchdog: a silent slave stalls the bus until its master gives up.
    assign w_timeout = (TIMEOUT_CYCLES < 0);
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_gidx_nxt  = r_gidx;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            S_IDLE: begin
                if (|bus.m_cyc_i) begin
                    w_state_nxt = S_GRANT;
                    w_gidx_nxt  = w_rr_idx;
                    w_ptr_nxt   = w_rr_idx;
                end
            end
            S_GRANT: begin
                if (!w_g_cyc) begin
                    w_state_nxt = S_IDLE;
                end else if (w_g_stb && !w_any_hit) begin
                    w_state_nxt = S_ERR;
                end
            end
            S_ERR:   w_state_nxt = S_GRANT;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_gidx  <= '0;
            r_ptr   <= c_IDX_W'(NM - 1);
        end else begin
            r_state <= w_state_nxt;
            r_gidx  <= w_gidx_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    assign bus.grant_o = w_grant_oh;
    assign bus.s_adr_o = w_granted ? w_g_adr : '0;
    assign bus.s_dat_o = w_granted ? w_g_dat : '0;
    assign bus.s_we_o  = w_granted & w_g_we;
    assign bus.s_sel_o = w_granted ? w_g_sel : '0;
    assign bus.s_cyc_o = w_active ? w_sel_oh : '0;
    assign bus.s_stb_o = (w_active && w_g_stb) ? w_sel_oh : '0;
    assign bus.m_ack_o = (w_active && w_s_ack) ? w_grant_oh : '0;
    assign bus.m_err_o = ((r_state == S_ERR) || w_timeout) ? w_grant_oh : '0;
    assign bus.m_dat_o = w_active ? bus.s_dat_i[int'(w_sel_idx)*c_DW +: c_DW] : '0;

endmodule
`default_nettype wire

// File: tb/tb_wb_shared_bus_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_shared_bus_arb
// Purpose  : Directed and randomized checks of the shared-bus interconnect.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_shared_bus_arb;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int NM = 2;
    localparam int NS = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    wb_shared_bus_arb_if #(.WB_DATA_WIDTH(DW), .WB_ADDR_WIDTH(AW), .WB_SEL_WIDTH(SW),
                           .NM(NM), .NS(NS)) bus ();
    wb_shared_bus_arb #(.WB_DATA_WIDTH(DW), .WB_ADDR_WIDTH(AW), .WB_SEL_WIDTH(SW),
                        .NM(NM), .NS(NS)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    // Second instance with two overlapping windows at address 0.
    wb_shared_bus_arb_if #(.WB_DATA_WIDTH(DW), .WB_ADDR_WIDTH(AW), .WB_SEL_WIDTH(SW),
                           .NM(NM), .NS(2)) bus2 ();
    wb_shared_bus_arb #(.WB_DATA_WIDTH(DW), .WB_ADDR_WIDTH(AW), .WB_SEL_WIDTH(SW),
                        .NM(NM), .NS(2), .SLAVE_BASE(64'h0),
                        .SLAVE_MASK({32'hFFFF_F000, 32'hFFFF_0000}))
        dut2 (.clk_i(clk), .rst_i(rst), .bus(bus2));

    function automatic int ref_decode(input logic [AW-1:0] a);
        if ((a & 32'hFFFF_0000) == 32'h0000_0000) return 0;
        if ((a & 32'hFFFF_F000) == 32'h0001_0000) return 1;
        if ((a & 32'hFFFF_F000) == 32'h0002_0000) return 2;
        return -1;
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        case ($urandom_range(0, 4))
            0:       return {16'h0000, 16'($urandom)};
            1:       return 32'h0001_0000 | {20'h0, 12'($urandom)};
            2:       return 32'h0002_0000 | {20'h0, 12'($urandom)};
            3:       return 32'h0003_0000 | {20'h0, 12'($urandom)};
            default: return $urandom;
        endcase
    endfunction

    task automatic clear_inputs();
        bus.m_adr_i  = '0; bus.m_dat_i  = '0; bus.m_we_i  = '0; bus.m_sel_i  = '0;
        bus.m_stb_i  = '0; bus.m_cyc_i  = '0; bus.s_ack_i = '0; bus.s_dat_i  = '0;
        bus2.m_adr_i = '0; bus2.m_dat_i = '0; bus2.m_we_i = '0; bus2.m_sel_i = '0;
        bus2.m_stb_i = '0; bus2.m_cyc_i = '0; bus2.s_ack_i = '0; bus2.s_dat_i = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        bus.m_cyc_i = 2'b11; bus.m_stb_i = 2'b11; bus.s_ack_i = 3'b111;
        @(negedge clk); #1;
        n_tests++;
        if (bus.grant_o !== 2'b00) begin n_fail++; $display("FAIL reset_grant: got %b want 00", bus.grant_o); end
        n_tests++;
        if ({bus.s_stb_o, bus.s_cyc_o} !== 6'b0) begin
            n_fail++; $display("FAIL reset_strobes: got %b want 000000", {bus.s_stb_o, bus.s_cyc_o});
        end
        n_tests++;
        if ({bus.m_ack_o, bus.m_err_o, bus.m_dat_o, bus.s_adr_o} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got %h want 0", {bus.m_ack_o, bus.m_err_o, bus.m_dat_o, bus.s_adr_o});
        end
        clear_inputs();
    endtask

    task automatic test_single_read();
        do_reset();
        bus.m_adr_i = {32'h0, 32'h0000_0100}; bus.m_cyc_i = 2'b01; bus.m_stb_i = 2'b01;
        @(negedge clk); #1;
        n_tests++;
        if (bus.grant_o !== 2'b01) begin n_fail++; $display("FAIL read_grant: got %b want 01", bus.grant_o); end
        n_tests++;
        if (bus.s_stb_o !== 3'b001 || bus.s_adr_o !== 32'h0000_0100 || bus.m_ack_o !== 2'b00) begin
            n_fail++; $display("FAIL read_strobe: got stb %b adr %h ack %b want 001 00000100 00",
                               bus.s_stb_o, bus.s_adr_o, bus.m_ack_o);
        end
        bus.s_ack_i = 3'b001; bus.s_dat_i = {32'h1111_1111, 32'h2222_2222, 32'hCAFE_F00D};
        #1;
        n_tests++;
        if (bus.m_ack_o !== 2'b01 || bus.m_dat_o !== 32'hCAFE_F00D) begin
            n_fail++; $display("FAIL read_ack: got ack %b dat %h want 01 cafef00d", bus.m_ack_o, bus.m_dat_o);
        end
        @(negedge clk);
        clear_inputs();
        @(negedge clk); #1;
        n_tests++;
        if (bus.grant_o !== 2'b00) begin n_fail++; $display("FAIL read_release: got %b want 00", bus.grant_o); end
    endtask

    task automatic test_round_robin();
        do_reset();
        bus.m_adr_i = {32'h0001_0000, 32'h0000_0200}; bus.m_cyc_i = 2'b11; bus.m_stb_i = 2'b11;
        @(negedge clk); #1;
        n_tests++;
        if (bus.grant_o !== 2'b01) begin n_fail++; $display("FAIL rr_first: got %b want 01", bus.grant_o); end
        bus.m_cyc_i = 2'b10; bus.m_stb_i = 2'b10;
        @(negedge clk); #1;
        n_tests++;
        if (bus.grant_o !== 2'b00) begin n_fail++; $display("FAIL rr_idle_gap: got %b want 00", bus.grant_o); end
        @(negedge clk); #1;
        n_tests++;
        if (bus.grant_o !== 2'b10 || bus.s_stb_o !== 3'b010) begin
            n_fail++; $display("FAIL rr_second: got grant %b stb %b want 10 010", bus.grant_o, bus.s_stb_o);
        end
        bus.m_cyc_i = 2'b00; bus.m_stb_i = 2'b00;
        @(negedge clk);
        bus.m_cyc_i = 2'b11; bus.m_stb_i = 2'b11;
        @(negedge clk); #1;
        n_tests++;
        if (bus.grant_o !== 2'b01) begin n_fail++; $display("FAIL rr_wrap: got %b want 01", bus.grant_o); end
    endtask

    task automatic test_unmapped();
        logic [NM-1:0] want;
        do_reset();
        bus.m_adr_i = {32'hDEAD_0000, 32'h0}; bus.m_we_i = 2'b10;
        bus.m_cyc_i = 2'b10; bus.m_stb_i = 2'b10;
        @(negedge clk); #1;
        n_tests++;
        if (bus.grant_o !== 2'b10 || bus.m_err_o !== 2'b00 || bus.s_stb_o !== 3'b000) begin
            n_fail++; $display("FAIL unmapped_first: got grant %b err %b stb %b want 10 00 000",
                               bus.grant_o, bus.m_err_o, bus.s_stb_o);
        end
        for (int k = 0; k < 3; k++) begin
            want = (k % 2 == 0) ? 2'b10 : 2'b00;
            @(negedge clk); #1;
            n_tests++;
            if (bus.m_err_o !== want || bus.s_stb_o !== 3'b000 || bus.s_cyc_o !== 3'b000) begin
                n_fail++; $display("FAIL unmapped_err[%0d]: got err %b stb %b want %b 000",
                                   k, bus.m_err_o, bus.s_stb_o, want);
            end
        end
        bus.m_cyc_i = 2'b00; bus.m_stb_i = 2'b00;
        @(negedge clk); #1;
        n_tests++;
        if (bus.m_err_o !== 2'b00) begin n_fail++; $display("FAIL unmapped_end: got %b want 00", bus.m_err_o); end
    endtask

    task automatic test_timeout();
        do_reset();
        bus.m_adr_i = {32'h0, 32'h0001_0004}; bus.m_cyc_i = 2'b01; bus.m_stb_i = 2'b01;
`ifdef WB_ARB_TIMEOUT_EN
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk); #1;
            n_tests++;
            if (bus.m_err_o !== ((k == 16) ? 2'b01 : 2'b00) ||
                bus.s_stb_o !== ((k == 16) ? 3'b000 : 3'b010)) begin
                n_fail++; $display("FAIL timeout_cycle %0d: got err %b stb %b", k, bus.m_err_o, bus.s_stb_o);
            end
        end
`else
        repeat (100) @(negedge clk);
        #1;
        n_tests++;
        if (bus.grant_o !== 2'b01 || bus.s_stb_o !== 3'b010 || bus.m_err_o !== 2'b00 || bus.m_ack_o !== 2'b00) begin
            n_fail++; $display("FAIL stall_100: got grant %b stb %b err %b ack %b want 01 010 00 00",
                               bus.grant_o, bus.s_stb_o, bus.m_err_o, bus.m_ack_o);
        end
`endif
        clear_inputs();
    endtask

    task automatic test_overlap();
        do_reset();
        bus2.m_adr_i = {32'h0, 32'h0000_0010}; bus2.m_cyc_i = 2'b01; bus2.m_stb_i = 2'b01;
        bus2.s_ack_i = 2'b10;
        @(negedge clk); #1;
        n_tests++;
        if (bus2.s_stb_o !== 2'b01 || bus2.s_cyc_o !== 2'b01) begin
            n_fail++; $display("FAIL overlap_sel: got stb %b cyc %b want 01 01", bus2.s_stb_o, bus2.s_cyc_o);
        end
        n_tests++;
        if (bus2.m_ack_o !== 2'b00) begin
            n_fail++; $display("FAIL overlap_foreign_ack: got %b want 00", bus2.m_ack_o);
        end
        clear_inputs();
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.m_adr_i = {32'h0, 32'h0000_0100}; bus.m_cyc_i = 2'b01; bus.m_stb_i = 2'b01;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if (bus.grant_o !== 2'b00 || bus.s_stb_o !== 3'b000 || bus.s_cyc_o !== 3'b000 || bus.s_adr_o !== 32'h0) begin
            n_fail++; $display("FAIL async_reset: got grant %b stb %b cyc %b adr %h want all 0",
                               bus.grant_o, bus.s_stb_o, bus.s_cyc_o, bus.s_adr_o);
        end
        clear_inputs();
        @(negedge clk);
        rst = 1'b0;
        bus.m_adr_i = {32'h0002_0000, 32'h0000_0100}; bus.m_cyc_i = 2'b11; bus.m_stb_i = 2'b11;
        @(negedge clk); #1;
        n_tests++;
        if (bus.grant_o !== 2'b01) begin n_fail++; $display("FAIL async_regrant: got %b want 01", bus.grant_o); end
        clear_inputs();
    endtask

    task automatic test_random(input int n_cycles);
        int               owner;
        int               ptr;
        int               sl;
        bit               in_err;
        bit               found;
        bit               busy [NM];
        bit               cool [NM];
        logic [AW-1:0]    ma [NM];
        logic [DW-1:0]    md [NM];
        logic             mw [NM];
        logic [SW-1:0]    ms [NM];
        logic [DW-1:0]    sd [NS];
        logic [NS-1:0]    sa;
        logic [NM-1:0]    cyc_v;
        logic [NM*AW-1:0] adr_v;
        logic [NM*DW-1:0] dat_v;
        logic [NM-1:0]    we_v;
        logic [NM*SW-1:0] sel_v;
        logic [NS*DW-1:0] sdat_v;
        logic [NM-1:0]    e_grant, e_ack, e_err;
        logic [NS-1:0]    e_cyc, e_stb;
        logic [DW-1:0]    e_dat;
        logic [AW+DW+SW:0] e_bc;
        do_reset();
        owner = -1; ptr = NM - 1; in_err = 1'b0;
        for (int m = 0; m < NM; m++) begin
            busy[m] = 1'b0; cool[m] = 1'b0; ma[m] = '0; md[m] = '0; mw[m] = 1'b0; ms[m] = '0;
        end
        for (int n = 0; n < n_cycles; n++) begin
            @(negedge clk);
            for (int m = 0; m < NM; m++) begin
                if (!busy[m] && !cool[m] && $urandom_range(0, 2) == 0) begin
                    busy[m] = 1'b1; ma[m] = rand_addr(); md[m] = $urandom;
                    mw[m] = 1'($urandom_range(0, 1)); ms[m] = SW'($urandom);
                end
                cool[m] = 1'b0;
                cyc_v[m] = busy[m];
                adr_v[m*AW +: AW] = ma[m]; dat_v[m*DW +: DW] = md[m];
                we_v[m] = mw[m]; sel_v[m*SW +: SW] = ms[m];
            end
            for (int s = 0; s < NS; s++) begin
                sa[s] = ($urandom_range(0, 2) != 0);
                sd[s] = $urandom;
                sdat_v[s*DW +: DW] = sd[s];
            end
            bus.m_cyc_i = cyc_v; bus.m_stb_i = cyc_v; bus.m_adr_i = adr_v;
            bus.m_dat_i = dat_v; bus.m_we_i = we_v; bus.m_sel_i = sel_v;
            bus.s_ack_i = sa; bus.s_dat_i = sdat_v;
            #1;
            e_grant = '0; e_ack = '0; e_err = '0; e_cyc = '0; e_stb = '0; e_dat = '0; e_bc = '0;
            if (owner >= 0) begin
                e_grant[owner] = 1'b1;
                e_bc = {ma[owner], md[owner], mw[owner], ms[owner]};
                if (in_err) begin
                    e_err[owner] = 1'b1;
                end else if (cyc_v[owner]) begin
                    sl = ref_decode(ma[owner]);
                    if (sl >= 0) begin
                        e_cyc[sl] = 1'b1; e_stb[sl] = 1'b1; e_dat = sd[sl];
                        e_ack[owner] = sa[sl];
                    end
                end
            end
            n_tests++;
            if (bus.grant_o !== e_grant) begin n_fail++; $display("FAIL rnd_grant @%0d: got %b want %b", n, bus.grant_o, e_grant); end
            n_tests++;
            if (bus.s_cyc_o !== e_cyc || bus.s_stb_o !== e_stb) begin
                n_fail++; $display("FAIL rnd_strobe @%0d: got %b/%b want %b/%b", n, bus.s_cyc_o, bus.s_stb_o, e_cyc, e_stb);
            end
            n_tests++;
            if (bus.m_ack_o !== e_ack || bus.m_err_o !== e_err) begin
                n_fail++; $display("FAIL rnd_resp @%0d: got ack %b err %b want %b %b", n, bus.m_ack_o, bus.m_err_o, e_ack, e_err);
            end
            n_tests++;
            if (bus.m_dat_o !== e_dat) begin n_fail++; $display("FAIL rnd_rdata @%0d: got %h want %h", n, bus.m_dat_o, e_dat); end
            n_tests++;
            if ({bus.s_adr_o, bus.s_dat_o, bus.s_we_o, bus.s_sel_o} !== e_bc) begin
                n_fail++; $display("FAIL rnd_bcast @%0d: got %h want %h", n,
                                   {bus.s_adr_o, bus.s_dat_o, bus.s_we_o, bus.s_sel_o}, e_bc);
            end
            if (owner >= 0 && (e_ack[owner] || e_err[owner])) begin
                busy[owner] = 1'b0; cool[owner] = 1'b1;
            end
            if (owner < 0) begin
                found = 1'b0;
                for (int i = 1; i <= NM; i++) begin
                    if (!found && cyc_v[(ptr + i) % NM]) begin
                        found = 1'b1; owner = (ptr + i) % NM; ptr = owner;
                    end
                end
            end else if (in_err) begin
                in_err = 1'b0;
            end else if (!cyc_v[owner]) begin
                owner = -1;
            end else if (ref_decode(ma[owner]) < 0) begin
                in_err = 1'b1;
            end
        end
        clear_inputs();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        test_reset();
        test_single_read();
        test_round_robin();
        test_unmapped();
        test_timeout();
        test_overlap();
        test_async_reset();
        test_random(400);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
